// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage load/store unit sitting between the control
// decoder and a single-port data cache. Aligns store data onto byte lanes,
// extracts and extends load data, and stalls the pipeline while busy.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// halfword or word access is rejected like a reserved funct3. When it is
// undefined, the low offset bits are ignored and the access is force-aligned.
//
// state | meaning
// IDLE  | no access outstanding; accept a new request
// REQ   | request latched; drive cache request, or flag a rejected access
// WAIT  | load handshaken; waiting for the cache response
module dmem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              st_done,
    output logic              misalign,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [3:0]        dc_we,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_resp_valid,
    input  logic [DATA_W-1:0] dc_resp_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_n;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              write_q;
    logic              bad_q;
    logic [DATA_W-1:0] ld_data_q;

    logic              rsvd_c;
    logic              misal_c;
    logic [3:0]        we_c;
    logic [DATA_W-1:0] wdata_c;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_ext;

    // Misaligned-access rejection exists only in the trapping build.
`ifdef MISALIGN_TRAP_EN
    assign misal_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    assign misal_c = 1'b0;
`endif

    // Classify the incoming request and build its lane enables and data.
    always_comb begin
        rsvd_c  = req_write ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        we_c    = 4'b0000;
        wdata_c = req_wdata;
        if (req_write) begin
            case (req_funct3[1:0])
                2'b00: begin
                    we_c    = 4'b0001 << req_addr[1:0];
                    wdata_c = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    we_c    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_c = {2{req_wdata[15:0]}};
                end
                default: we_c = 4'b1111;
            endcase
        end
        if (rsvd_c || misal_c) begin
            we_c = 4'b0000;
        end
    end

    // Latch the request on acceptance; cache-facing fields stay stable until handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
            write_q  <= 1'b0;
            bad_q    <= 1'b0;
            dc_addr  <= '0;
            dc_we    <= 4'b0000;
            dc_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            off_q    <= req_addr[1:0];
            f3_q     <= req_funct3;
            write_q  <= req_write;
            bad_q    <= rsvd_c || misal_c;
            dc_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            dc_we    <= we_c;
            dc_wdata <= wdata_c;
        end
    end

    // Pick the addressed byte/halfword of the response and extend it.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dc_resp_data[7:0];
            2'd1:    byte_sel = dc_resp_data[15:8];
            2'd2:    byte_sel = dc_resp_data[23:16];
            default: byte_sel = dc_resp_data[31:24];
        endcase
        half_sel = off_q[1] ? dc_resp_data[31:16] : dc_resp_data[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_ext = {24'h000000, byte_sel};
            3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_ext = {16'h0000, half_sel};
            default: ld_ext = dc_resp_data;
        endcase
    end

    // Hold the last completed load result between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_data_q <= '0;
        end else if (ld_valid) begin
            ld_data_q <= ld_ext;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake/pulse outputs; stall drops on any completion pulse.
    always_comb begin
        state_n      = state;
        stall        = 1'b0;
        dc_req_valid = 1'b0;
        st_done      = 1'b0;
        ld_valid     = 1'b0;
        misalign     = 1'b0;
        ld_data      = ld_data_q;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bad_q) begin
                    misalign = 1'b1;
                    state_n  = IDLE;
                end else begin
                    dc_req_valid = 1'b1;
                    stall        = 1'b1;
                    if (dc_req_ready) begin
                        if (write_q) begin
                            st_done = 1'b1;
                            stall   = 1'b0;
                            state_n = IDLE;
                        end else begin
                            state_n = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dc_resp_valid) begin
                    ld_valid = 1'b1;
                    ld_data  = ld_ext;
                    stall    = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

endmodule
